// File: rtl/bpl_fetch_sequencer.sv
// Bitplane DMA fetch-slot sequencer for one scanline.
// Decodes the data-fetch window and bitplane mode registers, walks fetch units
// across the window and emits one BPLxDAT register address per granted slot,
// plus end-of-line modulo strobes for the bitplane pointer logic.
module bpl_fetch_sequencer #(
  parameter logic [7:0] HARD_STOP   = 8'hD8,
  parameter int         OCS_MAX_BPU = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk7_en,
  input  logic        cck,
  input  logic [8:0]  hpos,
  input  logic        vbpl_en,
  input  logic        aga,
  input  logic [7:0]  reg_address_in,
  input  logic [15:0] data_in,
  output logic        fetch_req,
  output logic [2:0]  fetch_plane,
  output logic [7:0]  fetch_reg,
  output logic        mod_odd,
  output logic        mod_even,
  output logic        line_done
);

  // Register addresses are bits [8:1] of the byte address.
  localparam logic [7:0] ADDR_DDFSTRT = 8'h49;  // 0x092
  localparam logic [7:0] ADDR_DDFSTOP = 8'h4A;  // 0x094
  localparam logic [7:0] ADDR_BPLCON0 = 8'h80;  // 0x100
  localparam logic [7:0] ADDR_FMODE   = 8'hFE;  // 0x1FC
  localparam logic [7:0] BPLDAT_BASE  = 8'h88;  // 0x110 (BPL1DAT)

  typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

  logic tick;
  assign tick = clk7_en & cck;

  // Programmable registers (live values).
  logic [7:0] ddfstrt_reg;
  logic [7:0] ddfstop_reg;
  logic       hires_reg;
  logic       shres_reg;
  logic [3:0] bpu_reg;
  logic [1:0] fmode_reg;
  logic [3:0] bpu_dec;

  // Per-unit latched mode, fetch walk state, and registered outputs.
  state_t     state_reg, state_next;
  logic [4:0] ofs_reg, ofs_next;
  logic       lat_hires_reg, lat_shres_reg;
  logic [3:0] lat_bpu_reg;
  logic [1:0] lat_fmode_reg;
  logic       odd_seen_reg, odd_seen_next;
  logic       even_seen_reg, even_seen_next;
  logic       fetch_req_reg, fetch_req_next;
  logic [2:0] fetch_plane_reg, fetch_plane_next;
  logic [7:0] fetch_reg_reg, fetch_reg_next;
  logic       line_done_reg, line_done_next;
  logic       mod_odd_reg, mod_odd_next;
  logic       mod_even_reg, mod_even_next;

  logic       start_unit, step_unit, first_unit, end_line;
  logic       eff_hires, eff_shres;
  logic [3:0] eff_bpu;
  logic [1:0] eff_fmode;
  logic [2:0] slot_plane_w, slot_idx;
  logic       slot_live;
  logic [7:0] plane_allowed;

  // Last unit offset (L-1) for each fetch width: L = 8, 16, 16, 32 CCKs.
  function automatic logic [4:0] unit_last(input logic [1:0] fm);
    logic [4:0] r;
    case (fm)
      2'b00:   r = 5'd7;
      2'b11:   r = 5'd31;
      default: r = 5'd15;
    endcase
    return r;
  endfunction

  // Plane number (1-based, 0 = idle) fetched at slot offset o of a unit.
  function automatic logic [2:0] slot_plane(input logic hi, input logic sh, input logic [2:0] o);
    logic [2:0] p;
    if (sh) begin
      p = o[0] ? 3'd1 : 3'd2;
    end else if (hi) begin
      case (o[1:0])
        2'd0:    p = 3'd4;
        2'd1:    p = 3'd2;
        2'd2:    p = 3'd3;
        default: p = 3'd1;
      endcase
    end else begin
      case (o)
        3'd1:    p = 3'd4;
        3'd2:    p = 3'd6;
        3'd3:    p = 3'd2;
        3'd5:    p = 3'd3;
        3'd6:    p = 3'd5;
        3'd7:    p = 3'd1;
        default: p = 3'd0;
      endcase
    end
    return p;
  endfunction

  // BPLCON0 plane count: the fourth bit exists only on AGA; OCS caps the count.
  always_comb begin
    bpu_dec = {data_in[4] & aga, data_in[14:12]};
    if (!aga && (bpu_dec > 4'(OCS_MAX_BPU))) bpu_dec = 4'(OCS_MAX_BPU);
  end

  // Register bus decode; writes are accepted on every 7 MHz enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      ddfstrt_reg <= 8'd0;
      ddfstop_reg <= 8'd0;
      hires_reg   <= 1'b0;
      shres_reg   <= 1'b0;
      bpu_reg     <= 4'd0;
      fmode_reg   <= 2'd0;
    end else if (clk7_en) begin
      case (reg_address_in)
        ADDR_DDFSTRT: ddfstrt_reg <= {data_in[7:1], 1'b0};
        ADDR_DDFSTOP: ddfstop_reg <= {data_in[7:1], 1'b0};
        ADDR_BPLCON0: begin
          hires_reg <= data_in[15];
          shres_reg <= data_in[6] & aga;
          bpu_reg   <= bpu_dec;
        end
        ADDR_FMODE: if (aga) fmode_reg <= data_in[1:0];
        default: ;
      endcase
    end
  end

  // Next-state logic: window start, unit walk/wrap, line end and abort at line start.
  always_comb begin
    state_next = state_reg;
    ofs_next   = ofs_reg;
    start_unit = 1'b0;
    step_unit  = 1'b0;
    end_line   = 1'b0;
    if (tick) begin
      unique case (state_reg)
        IDLE: begin
          if ((hpos[7:0] == ddfstrt_reg) && vbpl_en) begin
            state_next = FETCH;
            ofs_next   = 5'd0;
            start_unit = 1'b1;
          end
        end
        FETCH: begin
          if (hpos == 9'd0) begin
            state_next = IDLE;
          end else if (ofs_reg == unit_last(lat_fmode_reg)) begin
            if ((hpos <= {1'b0, ddfstop_reg}) && (hpos <= {1'b0, HARD_STOP}) && vbpl_en) begin
              ofs_next   = 5'd0;
              start_unit = 1'b1;
            end else begin
              state_next = DONE;
              end_line   = 1'b1;
            end
          end else begin
            ofs_next  = ofs_reg + 5'd1;
            step_unit = 1'b1;
          end
        end
        DONE: begin
          if (hpos == 9'd0) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // A starting unit sees the live mode; a unit in progress uses what it latched.
  assign first_unit = start_unit && (state_reg == IDLE);
  assign eff_hires  = start_unit ? hires_reg : lat_hires_reg;
  assign eff_shres  = start_unit ? shres_reg : lat_shres_reg;
  assign eff_bpu    = start_unit ? bpu_reg   : lat_bpu_reg;
  assign eff_fmode  = start_unit ? fmode_reg : lat_fmode_reg;

  // Only the last 8 CCKs of a unit carry fetch slots.
  assign slot_live    = (start_unit || step_unit) && (ofs_next >= (unit_last(eff_fmode) - 5'd7));
  assign slot_plane_w = slot_plane(eff_hires, eff_shres, ofs_next[2:0]);
  assign slot_idx     = slot_plane_w - 3'd1;

  for (genvar gi = 0; gi < 8; gi++) begin : g_plane_en
    assign plane_allowed[gi] = (eff_bpu > 4'(gi));
  end

  // Output/next-flag logic: slot grant, plane parity tracking and end-of-line strobes.
  always_comb begin
    fetch_req_next   = 1'b0;
    fetch_plane_next = 3'd0;
    fetch_reg_next   = 8'd0;
    line_done_next   = 1'b0;
    mod_odd_next     = 1'b0;
    mod_even_next    = 1'b0;
    odd_seen_next    = first_unit ? 1'b0 : odd_seen_reg;
    even_seen_next   = first_unit ? 1'b0 : even_seen_reg;
    if (slot_live && (slot_plane_w != 3'd0) && plane_allowed[slot_idx]) begin
      fetch_req_next   = 1'b1;
      fetch_plane_next = slot_idx;
      fetch_reg_next   = BPLDAT_BASE + {5'd0, slot_idx};
      if (slot_plane_w[0]) odd_seen_next = 1'b1;
      else                 even_seen_next = 1'b1;
    end
    if (end_line) begin
      line_done_next = 1'b1;
      mod_odd_next   = odd_seen_reg;
      mod_even_next  = even_seen_reg;
    end
  end

  // State, unit latches and outputs; outputs change only on CCK ticks.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      ofs_reg         <= 5'd0;
      lat_hires_reg   <= 1'b0;
      lat_shres_reg   <= 1'b0;
      lat_bpu_reg     <= 4'd0;
      lat_fmode_reg   <= 2'd0;
      odd_seen_reg    <= 1'b0;
      even_seen_reg   <= 1'b0;
      fetch_req_reg   <= 1'b0;
      fetch_plane_reg <= 3'd0;
      fetch_reg_reg   <= 8'd0;
      line_done_reg   <= 1'b0;
      mod_odd_reg     <= 1'b0;
      mod_even_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      ofs_reg       <= ofs_next;
      odd_seen_reg  <= odd_seen_next;
      even_seen_reg <= even_seen_next;
      if (start_unit) begin
        lat_hires_reg <= hires_reg;
        lat_shres_reg <= shres_reg;
        lat_bpu_reg   <= bpu_reg;
        lat_fmode_reg <= fmode_reg;
      end
      if (tick) begin
        fetch_req_reg   <= fetch_req_next;
        fetch_plane_reg <= fetch_plane_next;
        fetch_reg_reg   <= fetch_reg_next;
        line_done_reg   <= line_done_next;
        mod_odd_reg     <= mod_odd_next;
        mod_even_reg    <= mod_even_next;
      end
    end
  end

  assign fetch_req   = fetch_req_reg;
  assign fetch_plane = fetch_plane_reg;
  assign fetch_reg   = fetch_reg_reg;
  assign line_done   = line_done_reg;
  assign mod_odd     = mod_odd_reg;
  assign mod_even    = mod_even_reg;

endmodule
